multicycle_control: RTL and testbench

- Moore-style multicycle control FSM for the RV64I-subset datapath.
- Consumes the 32-bit instruction-register value exported by the datapath (`instruction_out`).
- Drives every datapath control flag, sequencing fetch/decode/execute/memory/writeback per instruction.
- Also flags illegal instructions (halts) and counts retired instructions for debug/perf.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the RV64I-subset datapath.
// master: the control FSM (consumes the IR, drives every datapath flag).
// slave:  the datapath side (supplies the IR, observes the flags).
interface multicycle_control_if;
  logic [31:0] instruction_in;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        PCSource;
  logic        ALUSrcA;
  logic        LoadAOut;
  logic        RegWrite;
  logic        LoadRegA;
  logic        LoadRegB;
  logic        MemToReg;
  logic        DMemOp;
  logic        LoadMDR;
  logic        IMemRead;
  logic        IRWrite;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        halted;
  logic [3:0]  state_out;
  logic [31:0] instr_retired;

  modport master (
    input  instruction_in,
    output PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA, LoadRegB,
    output MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite, ALUSrcB, ALUOp,
    output halted, state_out, instr_retired
  );

  modport slave (
    output instruction_in,
    input  PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA, LoadRegB,
    input  MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite, ALUSrcB, ALUOp,
    input  halted, state_out, instr_retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore multicycle control FSM for the RV64I-subset datapath. Sequences
// fetch/decode/execute/memory/writeback, halts on illegal encodings and
// counts retired instructions.
module multicycle_control #(
  parameter logic [31:0] RESET_COUNT = 32'h0
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StRst      = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StExecR    = 4'd3,
    StExecI    = 4'd4,
    StAluWb    = 4'd5,
    StMemAddr  = 4'd6,
    StMemRead  = 4'd7,
    StMemWb    = 4'd8,
    StMemWrite = 4'd9,
    StBranch   = 4'd10,
    StHalt     = 4'd11
  } state_e;

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e      state_q, state_d;
  // Remembers whether the ALU_WB being entered came from EXEC_R (1) or EXEC_I (0).
  logic        rtype_q, rtype_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.instruction_in[6:0];
  assign funct3 = bus.instruction_in[14:12];
  assign funct7 = bus.instruction_in[31:25];

  logic       r_legal, i_legal;
  logic [1:0] r_aluop, i_aluop;

  // R-type ALU op decode; illegal combinations leave ALUOp at add.
  always_comb begin
    r_legal = 1'b1;
    r_aluop = 2'b00;
    case ({funct7, funct3})
      10'b0000000_000: r_aluop = 2'b00;
      10'b0100000_000: r_aluop = 2'b01;
      10'b0000000_111: r_aluop = 2'b10;
      10'b0000000_110: r_aluop = 2'b11;
      default:         r_legal = 1'b0;
    endcase
  end

  // I-type ALU op decode; funct7 is part of the immediate here.
  always_comb begin
    i_legal = 1'b1;
    i_aluop = 2'b00;
    case (funct3)
      3'b000:  i_aluop = 2'b00;
      3'b111:  i_aluop = 2'b10;
      3'b110:  i_aluop = 2'b11;
      default: i_legal = 1'b0;
    endcase
  end

  // Next-state and Moore flag decode.
  always_comb begin
    state_d          = state_q;
    rtype_d          = rtype_q;
    retire           = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.PCSource     = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.LoadAOut     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.LoadRegA     = 1'b0;
    bus.LoadRegB     = 1'b0;
    bus.MemToReg     = 1'b0;
    bus.DMemOp       = 1'b0;
    bus.LoadMDR      = 1'b0;
    bus.IMemRead     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.ALUOp        = 2'b00;
    unique case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        bus.IMemRead = 1'b1;
        bus.IRWrite  = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.ALUSrcB  = 2'b01;
        state_d      = StDecode;
      end
      StDecode: begin
        bus.LoadRegA = 1'b1;
        bus.LoadRegB = 1'b1;
        bus.LoadAOut = 1'b1;
        bus.ALUSrcB  = 2'b11;
        if (opcode == OpRType) begin
          state_d = StExecR;
        end else if (opcode == OpIType) begin
          state_d = StExecI;
        end else if ((opcode == OpLoad || opcode == OpStore) && funct3 == 3'b011) begin
          state_d = StMemAddr;
        end else if (opcode == OpBranch && funct3 == 3'b000) begin
          state_d = StBranch;
        end else begin
          state_d = StHalt;
        end
      end
      StExecR: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b00;
        bus.LoadAOut = 1'b1;
        bus.ALUOp    = r_aluop;
        rtype_d      = 1'b1;
        state_d      = r_legal ? StAluWb : StHalt;
      end
      StExecI: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b10;
        bus.LoadAOut = 1'b1;
        bus.ALUOp    = i_aluop;
        rtype_d      = 1'b0;
        state_d      = i_legal ? StAluWb : StHalt;
      end
      StAluWb: begin
        // IR is stable until the next FETCH, so the EXEC decode is still valid here.
        bus.RegWrite = 1'b1;
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = rtype_q ? 2'b00 : 2'b10;
        bus.ALUOp    = rtype_q ? r_aluop : i_aluop;
        retire       = 1'b1;
        state_d      = StFetch;
      end
      StMemAddr: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b10;
        bus.LoadAOut = 1'b1;
        state_d      = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.LoadMDR = 1'b1;
        state_d     = StMemWb;
      end
      StMemWb: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
        retire       = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.DMemOp  = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 1'b1;
        retire          = 1'b1;
        state_d         = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_comb begin
    retired_d = retired_q;
    if (retire) begin
      retired_d = retired_q + 32'd1;
    end
  end

  // State, EXEC-kind and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRst;
      rtype_q   <= 1'b0;
      retired_q <= RESET_COUNT;
    end else begin
      state_q   <= state_d;
      rtype_q   <= rtype_d;
      retired_q <= retired_d;
    end
  end

  assign bus.halted        = (state_q == StHalt);
  assign bus.state_out     = state_q;
  assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, hand-written
// halt/reset/wrap sequences and randomized instructions against a plan-based model.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control_if bus2 ();

  multicycle_control #(.RESET_COUNT(32'h0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  multicycle_control #(.RESET_COUNT(32'hFFFF_FFFF)) dut_wrap (
    .clk  (clk),
    .reset(reset2),
    .bus  (bus2)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic       load_aout;
    logic       reg_write;
    logic       load_reg_a;
    logic       load_reg_b;
    logic       mem_to_reg;
    logic       dmem_op;
    logic       load_mdr;
    logic       imem_read;
    logic       ir_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } flags_t;

  typedef struct packed {
    logic [3:0] st;
    flags_t     f;
  } step_t;

  typedef struct {
    logic [31:0] ins;
    string       name;
    int          cycles;
    int          exec_st;
    logic [1:0]  alu_op;
    logic [1:0]  alu_src_b;
  } vec_t;

  step_t       plan[$];
  bit          plan_halts;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_retired;

  function automatic flags_t dut_flags();
    flags_t f;
    f.pc_write      = bus.PCWrite;
    f.pc_write_cond = bus.PCWriteCond;
    f.pc_source     = bus.PCSource;
    f.alu_src_a     = bus.ALUSrcA;
    f.load_aout     = bus.LoadAOut;
    f.reg_write     = bus.RegWrite;
    f.load_reg_a    = bus.LoadRegA;
    f.load_reg_b    = bus.LoadRegB;
    f.mem_to_reg    = bus.MemToReg;
    f.dmem_op       = bus.DMemOp;
    f.load_mdr      = bus.LoadMDR;
    f.imem_read     = bus.IMemRead;
    f.ir_write      = bus.IRWrite;
    f.alu_src_b     = bus.ALUSrcB;
    f.alu_op        = bus.ALUOp;
    f.halted        = bus.halted;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input flags_t f);
    plan.push_back({st, f});
  endtask

  // Build the expected per-cycle (state, flags) walk of one instruction, starting
  // in FETCH and ending either back in FETCH or in HALT.
  task automatic build_plan(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] aop;
    bit         legal;
    flags_t     f;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    plan.delete();
    plan_halts = 1'b0;
    f = '0; f.imem_read = 1; f.ir_write = 1; f.pc_write = 1; f.alu_src_b = 2'b01;
    push(4'd1, f);
    f = '0; f.load_reg_a = 1; f.load_reg_b = 1; f.load_aout = 1; f.alu_src_b = 2'b11;
    push(4'd2, f);
    if (op == 7'h33 || op == 7'h13) begin
      legal = 1'b1;
      aop   = 2'b00;
      if (op == 7'h33) begin
        if (f7 == 7'h00 && f3 == 3'd0) aop = 2'b00;
        else if (f7 == 7'h20 && f3 == 3'd0) aop = 2'b01;
        else if (f7 == 7'h00 && f3 == 3'd7) aop = 2'b10;
        else if (f7 == 7'h00 && f3 == 3'd6) aop = 2'b11;
        else legal = 1'b0;
      end else begin
        if (f3 == 3'd0) aop = 2'b00;
        else if (f3 == 3'd7) aop = 2'b10;
        else if (f3 == 3'd6) aop = 2'b11;
        else legal = 1'b0;
      end
      f = '0; f.alu_src_a = 1; f.load_aout = 1; f.alu_op = aop;
      f.alu_src_b = (op == 7'h33) ? 2'b00 : 2'b10;
      push((op == 7'h33) ? 4'd3 : 4'd4, f);
      if (legal) begin
        f.load_aout = 0; f.reg_write = 1;
        push(4'd5, f);
      end else begin
        plan_halts = 1'b1;
      end
    end else if ((op == 7'h03 || op == 7'h23) && f3 == 3'd3) begin
      f = '0; f.alu_src_a = 1; f.alu_src_b = 2'b10; f.load_aout = 1;
      push(4'd6, f);
      f.load_aout = 0;
      if (op == 7'h03) begin
        f.load_mdr = 1;
        push(4'd7, f);
        f = '0; f.reg_write = 1; f.mem_to_reg = 1;
        push(4'd8, f);
      end else begin
        f.dmem_op = 1;
        push(4'd9, f);
      end
    end else if (op == 7'h63 && f3 == 3'd0) begin
      f = '0; f.alu_src_a = 1; f.alu_op = 2'b01; f.pc_write_cond = 1; f.pc_source = 1;
      push(4'd10, f);
    end else begin
      plan_halts = 1'b1;
    end
    if (plan_halts) begin
      f = '0; f.halted = 1;
      push(4'd11, f);
    end else begin
      f = '0; f.imem_read = 1; f.ir_write = 1; f.pc_write = 1; f.alu_src_b = 2'b01;
      push(4'd1, f);
    end
  endtask

  // Called at a falling edge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input string tag, input int exp_cycles,
                           input int exec_st, input logic [1:0] exp_op,
                           input logic [1:0] exp_srcb);
    int          fetch_at;
    logic [31:0] cnt_exp;
    build_plan(ins);
    bus.instruction_in = ins;
    fetch_at = -1;
    chk($sformatf("%s state[0]", tag), bus.state_out, plan[0].st);
    chk($sformatf("%s flags[0]", tag), dut_flags(), plan[0].f);
    for (int k = 1; k < plan.size(); k++) begin
      @(negedge clk);
      cnt_exp = (!plan_halts && k == plan.size() - 1) ? exp_retired + 32'd1 : exp_retired;
      chk($sformatf("%s state[%0d]", tag, k), bus.state_out, plan[k].st);
      chk($sformatf("%s flags[%0d]", tag, k), dut_flags(), plan[k].f);
      chk($sformatf("%s retired[%0d]", tag, k), bus.instr_retired, cnt_exp);
      if (bus.state_out == 4'd1 && fetch_at < 0) fetch_at = k;
      if (exec_st >= 0 && bus.state_out == exec_st[3:0]) begin
        chk($sformatf("%s exec ALUOp", tag), bus.ALUOp, exp_op);
        chk($sformatf("%s exec ALUSrcB", tag), bus.ALUSrcB, exp_srcb);
      end
    end
    if (exp_cycles > 0) chk($sformatf("%s latency", tag), fetch_at, exp_cycles);
    if (!plan_halts) exp_retired = exp_retired + 32'd1;
  endtask

  task automatic halt_hold(input int n, input string tag);
    flags_t hf;
    hf = '0;
    hf.halted = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s halt state", tag), bus.state_out, 4'd11);
      chk($sformatf("%s halt flags", tag), dut_flags(), hf);
      chk($sformatf("%s halt retired", tag), bus.instr_retired, exp_retired);
    end
  endtask

  // Pulse reset from a falling edge; returns at a falling edge with the DUT in FETCH.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk($sformatf("%s rst state", tag), bus.state_out, 4'd0);
    chk($sformatf("%s rst flags", tag), dut_flags(), 0);
    chk($sformatf("%s rst retired", tag), bus.instr_retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_retired = 32'd0;
    @(negedge clk);
    chk($sformatf("%s recover", tag), bus.state_out, 4'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          c;
    int          sel;
    w = $urandom();
    c = $urandom_range(0, 7);
    case (c)
      0: begin
        sel = $urandom_range(0, 3);
        w[6:0] = 7'h33;
        w[31:25] = (sel == 1) ? 7'h20 : 7'h00;
        w[14:12] = (sel == 2) ? 3'd7 : (sel == 3) ? 3'd6 : 3'd0;
      end
      1: w[6:0] = 7'h33;
      2: w[6:0] = 7'h13;
      3: begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
      4: begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
      5: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
      6: begin
        sel = $urandom_range(0, 2);
        w[6:0] = (sel == 0) ? 7'h03 : (sel == 1) ? 7'h23 : 7'h63;
      end
      default: ;
    endcase
    return w;
  endfunction

  vec_t vecs[$];

  initial begin
    bit          seen_wb;
    bit          wrapped;
    logic [31:0] ins;

    vecs.push_back('{32'h002081B3, "add",  4, 3,  2'b00, 2'b00});
    vecs.push_back('{32'h402081B3, "sub",  4, 3,  2'b01, 2'b00});
    vecs.push_back('{32'h0020F1B3, "and",  4, 3,  2'b10, 2'b00});
    vecs.push_back('{32'h0020E1B3, "or",   4, 3,  2'b11, 2'b00});
    vecs.push_back('{32'h0FF0E193, "ori",  4, 4,  2'b11, 2'b10});
    vecs.push_back('{32'h00508193, "addi", 4, 4,  2'b00, 2'b10});
    vecs.push_back('{32'h0FF0F193, "andi", 4, 4,  2'b10, 2'b10});
    vecs.push_back('{32'h0080B283, "ld",   5, 6,  2'b00, 2'b10});
    vecs.push_back('{32'h0050B423, "sd",   4, 6,  2'b00, 2'b10});
    vecs.push_back('{32'h00208463, "beq",  3, 10, 2'b01, 2'b00});

    reset  = 1'b0;
    reset2 = 1'b0;
    bus.instruction_in  = 32'h0;
    bus2.instruction_in = 32'h002081B3;
    exp_retired = 32'd0;

    repeat (2) @(negedge clk);
    chk("reset state", bus.state_out, 4'd0);
    chk("reset flags", dut_flags(), 0);
    chk("reset retired", bus.instr_retired, 32'd0);
    chk("preload retired", bus2.instr_retired, 32'hFFFF_FFFF);

    // Preloaded counter wraps to zero on the first retire.
    reset2  = 1'b1;
    seen_wb = 1'b0;
    wrapped = 1'b0;
    for (int k = 0; k < 12 && !wrapped; k++) begin
      @(negedge clk);
      if (bus2.state_out == 4'd5) begin
        seen_wb = 1'b1;
      end else if (seen_wb && bus2.state_out == 4'd1) begin
        wrapped = 1'b1;
        chk("preload wrap value", bus2.instr_retired, 32'd0);
      end
    end
    chk("preload wrap reached", wrapped, 1'b1);
    reset2 = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("first fetch", bus.state_out, 4'd1);

    foreach (vecs[i]) begin
      run_instr(vecs[i].ins, vecs[i].name, vecs[i].cycles, vecs[i].exec_st,
                vecs[i].alu_op, vecs[i].alu_src_b);
    end

    run_instr(32'h0000007F, "illegal op", 0, -1, 2'b00, 2'b00);
    halt_hold(20, "illegal op");
    reset_pulse("illegal op");

    run_instr(32'h022081B3, "add f7=01", 0, -1, 2'b00, 2'b00);
    halt_hold(20, "add f7=01");
    reset_pulse("add f7=01");

    // Reset arriving in MEM_READ clears the flags without waiting for a clock.
    run_instr(32'h002081B3, "pre-ld add", 4, 3, 2'b00, 2'b00);
    bus.instruction_in = 32'h0080B283;
    repeat (3) @(negedge clk);
    chk("ld mid state", bus.state_out, 4'd7);
    chk("ld mid LoadMDR", bus.LoadMDR, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid reset LoadMDR", bus.LoadMDR, 1'b0);
    chk("mid reset state", bus.state_out, 4'd0);
    chk("mid reset retired", bus.instr_retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_retired = 32'd0;
    @(negedge clk);
    chk("mid reset recover", bus.state_out, 4'd1);

    for (int n = 0; n < 60; n++) begin
      ins = rand_instr();
      run_instr(ins, $sformatf("rnd%0d %08h", n, ins), 0, -1, 2'b00, 2'b00);
      if (plan_halts) begin
        halt_hold(3, $sformatf("rnd%0d", n));
        reset_pulse($sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
